// File: rtl/add_sub_rr_scheduler.sv
// add_sub_rr_scheduler: round-robin sharing of one 32b add/sub unit with a registered tagged result port
module add_sub_rr_scheduler #(
  parameter int SIZE    = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    CGRA_Clock,
  input  logic                    CGRA_Reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*SIZE-1:0] req_a,
  input  logic [NUM_REQ*SIZE-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_op,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SIZE-1:0]         res_data,
  output logic [ID_W-1:0]         res_id,
  output logic [CNT_W-1:0]        issue_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, gnt_id, cand;
  logic [SIZE-1:0] a_sel, b_sel, sum;
  logic            op_sel, found, slot_free, grant;
  assign res_valid = state == FULL;
  assign slot_free = state == EMPTY || res_ready;
  // first valid requester at or after rr_ptr, wrapping; no grant while reset is asserted
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
    grant = found && slot_free && CGRA_Reset;
  end
  // one-hot accept on the winner
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_id] = 1'b1;
  end
  // steer the winner's operands into the shared add/sub unit
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gnt_id == ID_W'(k)) begin
        a_sel  = req_a[k*SIZE +: SIZE];
        b_sel  = req_b[k*SIZE +: SIZE];
        op_sel = req_op[k];
      end
    sum = op_sel ? a_sel - b_sel : a_sel + b_sel;
  end
  // slot fills on any grant, empties on a drain without refill
  always_comb state_nxt = grant ? FULL : (state == FULL && res_ready) ? EMPTY : state;
  // result register, pointer and saturating issue counter update on a grant
  always_ff @(posedge CGRA_Clock) begin
    if (!CGRA_Reset) begin
      state       <= EMPTY;
      rr_ptr      <= '0;
      issue_count <= '0;
      res_data    <= '0;
      res_id      <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        rr_ptr   <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        res_data <= sum;
        res_id   <= gnt_id;
        if (issue_count != '1) issue_count <= issue_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_add_sub_rr_scheduler.sv
// tb_add_sub_rr_scheduler: directed scoreboard bench for the round-robin add/sub scheduler
module tb_add_sub_rr_scheduler;
  logic         clk = 0;
  logic         rst_n = 0;
  logic [3:0]   req_valid = 0, req_ready, req_op = 0;
  logic [127:0] req_a = 0, req_b = 0;
  logic         res_valid, res_ready = 1;
  logic [31:0]  res_data;
  logic [1:0]   res_id;
  logic [15:0]  issue_count;
  typedef struct {logic [31:0] d; logic [1:0] id;} res_t;
  res_t q[$];
  int   n_vec = 0, n_err = 0;
  int   m_ptr = 0, m_cnt = 0, m_gnt;
  logic m_full = 0;
  add_sub_rr_scheduler dut (
    .CGRA_Clock(clk), .CGRA_Reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .issue_count(issue_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(int k, logic [31:0] a, logic [31:0] b, logic op);
    req_a[k*32 +: 32] = a;
    req_b[k*32 +: 32] = b;
    req_op[k] = op;
  endtask
  task automatic cycle();
    logic [31:0] a, b, r;
    #1;
    m_gnt = -1;
    if (rst_n && (!m_full || res_ready))
      for (int i = 0; i < 4; i++)
        if (m_gnt < 0 && req_valid[(m_ptr + i) % 4]) m_gnt = (m_ptr + i) % 4;
    chk("req_ready", 32'(req_ready), m_gnt >= 0 ? 32'(1) << m_gnt : 32'd0);
    chk("res_valid", 32'(res_valid), 32'(m_full));
    if (m_full && q.size() > 0) begin
      chk("res_data", res_data, q[0].d);
      chk("res_id", 32'(res_id), 32'(q[0].id));
    end
    chk("issue_count", 32'(issue_count), 32'(m_cnt));
    if (m_gnt >= 0) begin
      a = req_a[m_gnt*32 +: 32];
      b = req_b[m_gnt*32 +: 32];
      r = req_op[m_gnt] ? a - b : a + b;
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_full = 0;
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      if (m_full && res_ready && q.size() > 0) void'(q.pop_front());
      if (m_gnt >= 0) begin
        q.push_back('{r, 2'(m_gnt)});
        m_ptr = (m_gnt + 1) % 4;
        if (m_cnt < 65535) m_cnt++;
      end
      m_full = (m_gnt >= 0) || (m_full && !res_ready);
    end
    #1;
  endtask
  initial begin
    cycle();
    cycle();
    rst_n = 1;
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", 32'(res_id), 0);
    chk("rst_count", 32'(issue_count), 0);
    set_req(0, 5, 3, 0);
    req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    cycle();
    req_valid = 0;
    chk("t1_data", res_data, 8);
    chk("t1_id", 32'(res_id), 0);
    chk("t1_count", 32'(issue_count), 1);
    set_req(1, 3, 5, 1);
    req_valid = 4'b0010;
    cycle();
    chk("t2_sub", res_data, 32'hFFFF_FFFE);
    set_req(1, 32'hFFFF_FFFF, 1, 0);
    cycle();
    req_valid = 0;
    chk("t2_wrap", res_data, 0);
    chk("t2_id", 32'(res_id), 1);
    rst_n = 0;
    cycle();
    rst_n = 1;
    set_req(0, 100, 1, 0);
    set_req(1, 200, 2, 1);
    set_req(2, 32'h8000_0000, 32'h8000_0000, 0);
    set_req(3, 7, 9, 1);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t3_order", 32'(res_id), 32'(i % 4));
      chk("t3_count", 32'(issue_count), 32'(i + 1));
    end
    res_ready = 0;
    req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_hold_id", 32'(res_id), 3);
      chk("t4_hold_data", res_data, 32'hFFFF_FFFE);
    end
    res_ready = 1;
    #1 chk("t4_refill_ready", 32'(req_ready), 32'b0100);
    cycle();
    chk("t4_refill_id", 32'(res_id), 2);
    chk("t4_refill_data", res_data, 0);
    req_valid = 4'b1001;
    cycle();
    chk("t5_first", 32'(res_id), 3);
    req_valid = 4'b0001;
    cycle();
    chk("t5_wrap", 32'(res_id), 0);
    req_valid = 4'b1111;
    cycle();
    chk("t5_ptr1", 32'(res_id), 1);
    req_valid = 0;
    res_ready = 0;
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("t6_valid", 32'(res_valid), 0);
    chk("t6_count", 32'(issue_count), 0);
    res_ready = 1;
    req_valid = 4'b1111;
    cycle();
    chk("t6_first", 32'(res_id), 0);
    req_valid = 0;
    cycle();
    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
